fft_sequencer: RTL and testbench
================================

# fft_sequencer

Control and scheduling block for the 8-bit radix-2 FFT butterfly datapath. It buffers an N-point real input frame in bit-reversed order and walks the log2(N) stages × N/2 butterflies. For each butterfly it issues operands and a twiddle index to the external butterfly unit over a req/ack handshake, and writes the results back in place. When the transform is complete it streams the N complex bins out in natural order. It replaces switch-stepped manual sequencing of the butterfly.

## Interface
- N, 8, transform length (power of two, ≥4)
- LOG2N, 3, log2(N)
- DW, 8, sample/result width (two's complement)

- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  input sample strobe
- in_data  in  DW  real input sample (imag taken as 0)
- in_ready  out  1  high in LOAD state only
- start  in  1  begin transform (honoured only in READY)
- bf_req  out  1  butterfly request
- bf_ack  in  1  butterfly result valid / request accepted
- bf_w  out  LOG2N-1  twiddle index k of W_N^k
- bf_rea, bf_ima, bf_reb, bf_imb  out  DW each  operands A, B
- bf_rey, bf_imy, bf_rez, bf_imz  in  DW each  results Y→A slot, Z→B slot
- out_valid  out  1  output bin valid
- out_ready  in  1  consumer accepts bin
- out_idx  out  LOG2N  bin index
- out_re, out_im  out  DW each  bin value
- busy  out  1  high in RUN, NEXT and OUTPUT
- done  out  1  one-cycle pulse on last bin accepted

## Operation
- Storage: N×DW re array and N×DW im array, written only by this block.
- States: LOAD → READY → ISSUE ⇄ NEXT → OUTPUT → LOAD.
- LOAD: each in_valid cycle writes in_data to re[bitrev(cnt)] and 0 to im[bitrev(cnt)], then cnt++. After the N-th sample → READY.
- READY: on start → ISSUE with stage s=0, butterfly j=0. start in any other state is ignored. in_valid outside LOAD is ignored.
- Butterfly indexing for stage s, butterfly j:
  - half = 2^s, k = j mod half, g = j / half
  - a = g·2^(s+1) + k, b = a + half
  - bf_w = k << (LOG2N−1−s)
- ISSUE:
  - bf_req=1; operands are combinational reads of a and b.
  - Operands and bf_w must stay stable until bf_ack.
  - On the bf_ack cycle, store Y at a and Z at b, then → NEXT.
  - bf_ack outside ISSUE is ignored.
- NEXT (one cycle, bf_req=0):
  - j++; when j reaches N/2, set j=0 and s++.
  - If s has reached LOG2N → OUTPUT with idx=0; else → ISSUE.
- OUTPUT:
  - out_valid=1, presenting idx and re/im[idx].
  - On out_valid && out_ready, idx++.
  - On the last bin accepted: done=1 for one cycle → LOAD, cnt=0.
- Arithmetic: results are stored unmodified. Scaling and saturation belong to the butterfly unit.

## Timing
- Reset values:
  - state LOAD, cnt/s/j/idx = 0, both arrays cleared to 0
  - in_ready=1, bf_req=0, bf_w=0, out_valid=0, busy=0, done=0
  - operand outputs read 0, out_* outputs read 0
- Reset asserted in any state aborts immediately to the reset values; a partial frame is discarded.
- Load: N cycles minimum; READY is entered the cycle after the N-th in_valid.
- start sampled in READY: bf_req rises the next cycle.
- Per butterfly: at least 2 cycles (ISSUE with same-cycle ack, plus NEXT). With a zero-wait butterfly, the full transform takes (N/2)·LOG2N·2 cycles (24 for N=8).
- bf_req is never high on two consecutive butterflies without a low cycle between them.
- out_valid rises the cycle after the final NEXT. With out_ready held high, N cycles to drain.
- done coincides with the cycle after the last handshake. in_ready rises in the same cycle.

## Test plan
- Reset mid-OUTPUT (reset=0 for 1 cycle) → all outputs return to reset values; in_ready=1; arrays read 0.
- Load x=0..7, start → first issue shows bf_rea=0, bf_reb=4, bf_w=0 (bit-reversed storage). Address pairs required:
  - stage 0: (0,1)(2,3)(4,5)(6,7), bf_w 0,0,0,0
  - stage 1: (0,2)(1,3)(4,6)(5,7), bf_w 0,2,0,2
  - stage 2: (0,4)(1,5)(2,6)(3,7), bf_w 0,1,2,3
- Impulse x0=16, others 0, with a reference butterfly model acking same-cycle → 8 bins, all re=16 im=0, idx 0..7. done pulses once. Total RUN = 24 cycles.
- bf_ack held low 5 cycles in ISSUE → bf_req, operands and bf_w are constant for all 6 cycles. No write-back occurs before ack.
- start pulsed in LOAD and in_valid pulsed during ISSUE → no state change, no array write.
- out_ready toggled 1,0,0,1… during OUTPUT → idx advances only on handshake cycles. out_re/out_im hold steady while stalled.

Source files
------------

// File: rtl/fft_sequencer.sv
// fft_sequencer
// Control and scheduling for an in-place radix-2 FFT built around an external
// butterfly unit. A real N-point frame is loaded in bit-reversed order, the
// LOG2N x N/2 butterflies are issued over a req/ack handshake with results
// written back in place, and the N complex bins are then streamed out in
// natural order.
//
// Ports
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_in_valid, i_in_data       real input samples (accepted while o_in_ready)
//   i_start                     begin the transform (honoured only in READY)
//   o_bf_req, i_bf_ack          butterfly handshake
//   o_bf_w                      twiddle index k of W_N^k
//   o_bf_re/ima/reb/imb         operands A (slot a) and B (slot b)
//   i_bf_rey/imy/rez/imz        results Y -> slot a, Z -> slot b
//   o_out_valid, i_out_ready    output bin handshake
//   o_out_idx, o_out_re/im      output bin index and value
//   o_busy                      high during ISSUE, NEXT and OUTPUT
//   o_done                      one-cycle pulse after the last bin is accepted
//
// state  | meaning
// LOAD   | collecting N samples into bit-reversed slots
// READY  | frame loaded, waiting for start
// ISSUE  | butterfly request outstanding, waiting for ack
// NEXT   | advance butterfly / stage counters
// OUTPUT | streaming bins in natural order
module fft_sequencer #(
  parameter int N     = 8,
  parameter int LOG2N = 3,
  parameter int DW    = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_in_valid,
  input  logic [DW-1:0]      i_in_data,
  output logic               o_in_ready,
  input  logic               i_start,
  output logic               o_bf_req,
  input  logic               i_bf_ack,
  output logic [LOG2N-2:0]   o_bf_w,
  output logic [DW-1:0]      o_bf_rea,
  output logic [DW-1:0]      o_bf_ima,
  output logic [DW-1:0]      o_bf_reb,
  output logic [DW-1:0]      o_bf_imb,
  input  logic [DW-1:0]      i_bf_rey,
  input  logic [DW-1:0]      i_bf_imy,
  input  logic [DW-1:0]      i_bf_rez,
  input  logic [DW-1:0]      i_bf_imz,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [LOG2N-1:0]   o_out_idx,
  output logic [DW-1:0]      o_out_re,
  output logic [DW-1:0]      o_out_im,
  output logic               o_busy,
  output logic               o_done
);

  localparam int JW = LOG2N - 1;
  localparam int SW = (LOG2N > 2) ? $clog2(LOG2N) : 1;

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_READY  = 3'd1,
    S_ISSUE  = 3'd2,
    S_NEXT   = 3'd3,
    S_OUTPUT = 3'd4
  } state_t;

  state_t            r_state;
  logic [LOG2N-1:0]  r_cnt;
  logic [SW-1:0]     r_s;
  logic [JW-1:0]     r_j;
  logic [LOG2N-1:0]  r_idx;
  logic [DW-1:0]     r_re [N];
  logic [DW-1:0]     r_im [N];
  logic              r_in_ready;
  logic              r_bf_req;
  logic              r_out_valid;
  logic              r_busy;
  logic              r_done;

  function automatic logic [LOG2N-1:0] f_bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  // Butterfly addressing: half = 2^s, k = j mod half, a = (j - k)*2 + k, b = a + half.
  // Bit s of a is always zero, so b is formed by OR-ing in half.
  logic [LOG2N-1:0] w_j_ext;
  logic [LOG2N-1:0] w_half;
  logic [LOG2N-1:0] w_kmask;
  logic [LOG2N-1:0] w_k;
  logic [LOG2N-1:0] w_a;
  logic [LOG2N-1:0] w_b;
  logic [JW-1:0]    w_k_narrow;
  logic             w_j_last;
  logic             w_s_last;

  assign w_j_ext    = {1'b0, r_j};
  assign w_half     = {{(LOG2N-1){1'b0}}, 1'b1} << r_s;
  assign w_kmask    = w_half - 1'b1;
  assign w_k        = w_j_ext & w_kmask;
  assign w_a        = ((w_j_ext & ~w_kmask) << 1) | w_k;
  assign w_b        = w_a | w_half;
  assign w_k_narrow = w_k[JW-1:0];
  assign w_j_last   = (r_j == JW'(N/2 - 1));
  assign w_s_last   = (r_s == SW'(LOG2N - 1));

  // Operands are live reads; they stay stable through a stall because s, j and
  // the arrays only change on the ack cycle.
  assign o_bf_rea = r_re[w_a];
  assign o_bf_ima = r_im[w_a];
  assign o_bf_reb = r_re[w_b];
  assign o_bf_imb = r_im[w_b];
  assign o_bf_w   = w_k_narrow << (SW'(LOG2N - 1) - r_s);

  assign o_out_idx   = r_idx;
  assign o_out_re    = r_re[r_idx];
  assign o_out_im    = r_im[r_idx];
  assign o_in_ready  = r_in_ready;
  assign o_bf_req    = r_bf_req;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_LOAD;
      r_cnt       <= '0;
      r_s         <= '0;
      r_j         <= '0;
      r_idx       <= '0;
      for (int i = 0; i < N; i++) begin
        r_re[i] <= '0;
        r_im[i] <= '0;
      end
      r_in_ready  <= 1'b1;
      r_bf_req    <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (i_in_valid) begin
            r_re[f_bitrev(r_cnt)] <= i_in_data;
            r_im[f_bitrev(r_cnt)] <= '0;
            if (r_cnt == LOG2N'(N - 1)) begin
              r_cnt      <= '0;
              r_in_ready <= 1'b0;
              r_state    <= S_READY;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        S_READY: begin
          if (i_start) begin
            r_s      <= '0;
            r_j      <= '0;
            r_bf_req <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (i_bf_ack) begin
            r_re[w_a] <= i_bf_rey;
            r_im[w_a] <= i_bf_imy;
            r_re[w_b] <= i_bf_rez;
            r_im[w_b] <= i_bf_imz;
            r_bf_req  <= 1'b0;
            r_state   <= S_NEXT;
          end
        end

        S_NEXT: begin
          if (w_j_last) begin
            r_j <= '0;
            if (w_s_last) begin
              // s is parked at 0 so the twiddle shift never goes out of range.
              r_s         <= '0;
              r_idx       <= '0;
              r_out_valid <= 1'b1;
              r_state     <= S_OUTPUT;
            end else begin
              r_s      <= r_s + 1'b1;
              r_bf_req <= 1'b1;
              r_state  <= S_ISSUE;
            end
          end else begin
            r_j      <= r_j + 1'b1;
            r_bf_req <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end

        S_OUTPUT: begin
          if (i_out_ready) begin
            if (r_idx == LOG2N'(N - 1)) begin
              r_idx       <= '0;
              r_cnt       <= '0;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_in_ready  <= 1'b1;
              r_done      <= 1'b1;
              r_state     <= S_LOAD;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end

        default: begin
          r_state     <= S_LOAD;
          r_in_ready  <= 1'b1;
          r_bf_req    <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_sequencer.sv
// Directed bench for fft_sequencer (N=8, DW=8).
module tb_fft_sequencer;
  localparam int N = 8, LOG2N = 3, DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          start = 1'b0;
  logic          bf_req;
  logic          bf_ack = 1'b0;
  logic [LOG2N-2:0] bf_w;
  logic [DW-1:0] bf_rea, bf_ima, bf_reb, bf_imb;
  logic [DW-1:0] bf_rey = '0, bf_imy = '0, bf_rez = '0, bf_imz = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [LOG2N-1:0] out_idx;
  logic [DW-1:0] out_re, out_im;
  logic          busy;
  logic          done;

  fft_sequencer #(.N(N), .LOG2N(LOG2N), .DW(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
    .i_start(start),
    .o_bf_req(bf_req), .i_bf_ack(bf_ack), .o_bf_w(bf_w),
    .o_bf_rea(bf_rea), .o_bf_ima(bf_ima), .o_bf_reb(bf_reb), .o_bf_imb(bf_imb),
    .i_bf_rey(bf_rey), .i_bf_imy(bf_imy), .i_bf_rez(bf_rez), .i_bf_imz(bf_imz),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_idx(out_idx),
    .o_out_re(out_re), .o_out_im(out_im),
    .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected butterfly slot pairs and twiddles, stage by stage.
  int ta [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
  int tbb[12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
  int tw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};
  // W_8^k in Q7: (cos, -sin)
  int wr [4]  = '{128,  91,    0, -91};
  int wi [4]  = '{  0, -91, -128, -91};

  int s_cur, idx_exp, cyc, b2b, done_cnt;
  logic [31:0] hold_ops, hold_ctl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int brev3(input int v);
    return ((v & 1) << 2) | (v & 2) | ((v >> 2) & 1);
  endfunction

  // Reference butterfly: Y = A + W*B, Z = A - W*B, W in Q7.
  task automatic bf_model;
    int ar, ai, br, bi, tr, ti, k;
    ar = int'($signed(bf_rea)); ai = int'($signed(bf_ima));
    br = int'($signed(bf_reb)); bi = int'($signed(bf_imb));
    k  = int'(bf_w);
    tr = (br * wr[k] - bi * wi[k]) >>> 7;
    ti = (br * wi[k] + bi * wr[k]) >>> 7;
    bf_rey = DW'(ar + tr); bf_imy = DW'(ai + ti);
    bf_rez = DW'(ar - tr); bf_imz = DW'(ai - ti);
  endtask

  task automatic load_impulse;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = (i == 0) ? 8'd16 : 8'd0;
      tick;
    end
    in_valid = 1'b0;
  endtask

  // Zero-wait butterfly: ack in the same cycle the request is seen.
  task automatic run_zero_wait(output int cycles, output int back2back);
    logic prev;
    prev = 1'b0;
    cycles = 0;
    back2back = 0;
    while (!out_valid && cycles < 100) begin
      if (bf_req) begin
        bf_model;
        bf_ack = 1'b1;
      end else begin
        bf_ack = 1'b0;
      end
      if (bf_req && prev) back2back++;
      prev = bf_req;
      tick;
      cycles++;
    end
    bf_ack = 1'b0;
  endtask

  initial begin
    // Reset values
    rst_n = 1'b0;
    tick; tick;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_bf_req", bf_req, 0);
    chk("rst_bf_w", bf_w, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ops", {bf_rea, bf_ima, bf_reb, bf_imb}, 0);
    chk("rst_out", {out_idx, out_re, out_im}, 0);
    rst_n = 1'b1;
    tick;

    // start in LOAD is ignored
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start_in_load_ready", in_ready, 1);
    chk("start_in_load_req", bf_req, 0);
    chk("start_in_load_busy", busy, 0);

    // Load x = 0..7
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      tick;
      if (i == N - 2) chk("load_7_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    chk("ready_in_ready", in_ready, 0);
    chk("ready_busy", busy, 0);

    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start_req", bf_req, 1);
    chk("start_busy", busy, 1);

    // Pass-through butterfly (Y=A, im+1; Z=B, im+2) keeps reals in bit-reversed
    // order so each operand names its slot; the imag tags expose where writes land.
    for (int i = 0; i < 12; i++) begin
      s_cur = i / 4;
      chk("bf_req_issue", bf_req, 1);
      chk("bf_rea", bf_rea, brev3(ta[i]));
      chk("bf_reb", bf_reb, brev3(tbb[i]));
      chk("bf_w", bf_w, tw[i]);
      chk("bf_ima", bf_ima, s_cur + $countones(ta[i] & ((1 << s_cur) - 1)));
      chk("bf_imb", bf_imb, s_cur + $countones(tbb[i] & ((1 << s_cur) - 1)));
      if (i == 4) begin
        hold_ops = {bf_rea, bf_ima, bf_reb, bf_imb};
        hold_ctl = {29'd0, bf_w, bf_req};
        bf_ack = 1'b0;
        for (int c = 0; c < 5; c++) begin
          in_valid = (c == 1);
          in_data  = 8'h63;
          tick;
          chk("stall_ops", {bf_rea, bf_ima, bf_reb, bf_imb}, hold_ops);
          chk("stall_ctl", {29'd0, bf_w, bf_req}, hold_ctl);
        end
        in_valid = 1'b0;
      end
      bf_rey = bf_rea; bf_imy = bf_ima + 8'd1;
      bf_rez = bf_reb; bf_imz = bf_imb + 8'd2;
      bf_ack = 1'b1;
      tick;
      bf_ack = 1'b0;
      chk("next_req_low", bf_req, 0);
      chk("next_busy", busy, 1);
      tick;
    end
    chk("output_valid", out_valid, 1);
    chk("output_busy", busy, 1);

    // Drain with out_ready pattern 1,0,0,1
    idx_exp = 0;
    cyc = 0;
    while (idx_exp < N && cyc < 64) begin
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      chk("out_valid", out_valid, 1);
      chk("out_idx", out_idx, idx_exp);
      chk("out_re", out_re, brev3(idx_exp));
      chk("out_im", out_im, 3 + $countones(idx_exp));
      chk("out_done_early", done, 0);
      tick;
      if (out_ready) idx_exp++;
      cyc++;
    end
    out_ready = 1'b0;
    chk("drain_timeout", idx_exp, N);
    chk("done_pulse", done, 1);
    chk("done_in_ready", in_ready, 1);
    chk("done_out_valid", out_valid, 0);
    chk("done_busy", busy, 0);
    tick;
    chk("done_drop", done, 0);

    // Impulse with reference butterfly
    load_impulse;
    chk("imp_ready", in_ready, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    run_zero_wait(cyc, b2b);
    chk("imp_run_cycles", cyc, 24);
    chk("imp_no_b2b_req", b2b, 0);
    out_ready = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < N + 2; c++) begin
      if (c < N) begin
        chk("imp_idx", out_idx, c);
        chk("imp_re", out_re, 16);
        chk("imp_im", out_im, 0);
      end
      if (done) done_cnt++;
      tick;
    end
    out_ready = 1'b0;
    chk("imp_done_count", done_cnt, 1);

    // Reset mid-OUTPUT
    load_impulse;
    start = 1'b1;
    tick;
    start = 1'b0;
    run_zero_wait(cyc, b2b);
    chk("rst2_in_output", out_valid, 1);
    out_ready = 1'b1;
    tick; tick;
    out_ready = 1'b0;
    chk("rst2_idx_before", out_idx, 2);
    rst_n = 1'b0;
    #2;
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_in_ready", in_ready, 1);
    chk("rst2_busy", busy, 0);
    chk("rst2_bf_req", bf_req, 0);
    chk("rst2_out", {out_idx, out_re, out_im}, 0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("rst2_ops_cleared", {bf_rea, bf_ima, bf_reb, bf_imb}, 0);
    chk("rst2_bf_w", bf_w, 0);
    chk("rst2_in_ready_after", in_ready, 1);
    chk("rst2_out_re_after", out_re, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
